mdr_read_unit: RTL and testbench
================================

Name: mdr_read_unit

Overview:
- Read-side counterpart of the datapath register load path.
- Issues a read handshake to memory, captures the returned word into an internal data register, and presents it to the 32-bit bus.
- Sits between the memory model and the bus, alongside the MDR.
- Owns the read FSM, the request/ready handshake and an optional timeout counter.

Parameters:
DATA_WIDTH, 32, width of memory data and bus
ADDR_WIDTH, 32, width of memory address
TIMEOUT_CYCLES, 16, REQ-state cycles before abort (timeout build only)
CNT_WIDTH, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  single clock; all state changes on rising edge
clear  in  1  synchronous, active-high reset
rd_req  in  1  start a read; sampled only in IDLE
addr_in  in  ADDR_WIDTH  read address, captured with rd_req
bus_out_en  in  1  gate for bus_out
mem_ready  in  1  memory has valid data on mem_data_in
mem_data_in  in  DATA_WIDTH  memory read data
mem_addr  out  ADDR_WIDTH  registered address to memory
mem_rd  out  1  registered read strobe to memory
bus_out  out  DATA_WIDTH  data register when bus_out_en=1, else 0 (combinational gate)
data_valid  out  1  one-cycle pulse: new word captured
busy  out  1  high in any state other than IDLE
rd_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Interface: one clock, clk. Reset is clear: synchronous, active-high. Only rising edges of clk act.
- Reset values: state=IDLE; mem_addr=0; mem_rd=0; data register=0; data_valid=0; busy=0; rd_err=0; counter=0.
- clear outranks every other input on the same edge.
- clear mid-read drops mem_rd on that edge. The data register is zeroed and no data_valid is produced.
- IDLE: rd_req=1 at edge N -> mem_addr<=addr_in, mem_rd<=1, state->REQ, counter<=0. busy is high from edge N.
- IDLE: mem_ready is ignored.
- REQ: mem_rd stays high.
- REQ, mem_ready=1 at edge M: data register<=mem_data_in, mem_rd<=0, data_valid<=1, state->DONE.
- REQ: rd_req is ignored (no queueing) and addr_in is not re-captured.
- DONE: lasts one cycle; data_valid<=0, state->IDLE. A rd_req during DONE is ignored.
- Minimum latency: rd_req at edge 0, mem_ready high at edge 1, data_valid high between edges 1 and 2. Back-to-back reads start every 3 cycles at best.
- The data register holds its value until the next successful capture or clear. bus_out reflects it immediately when bus_out_en=1.
- No arithmetic. Counter increments by 1 per REQ cycle and saturates; no wrap.

Optional Feature:
Macro MDR_READ_TIMEOUT_EN.
- Defined: the counter counts REQ cycles.
  - If counter reaches TIMEOUT_CYCLES-1 with mem_ready=0, then on the next edge: mem_rd<=0, rd_err<=1 for one cycle, state->IDLE. The data register is unchanged.
  - mem_ready=1 on that same edge wins: it is a normal capture, no rd_err.
- Undefined: no counter is synthesised, rd_err is tied 0, and REQ waits indefinitely.

Decomposition:
- Shared package mdr_pkg holds:
  - state encoding: IDLE=2'd0, REQ=2'd1, DONE=2'd2;
  - default width constants;
  - TIMEOUT_CYCLES default.
- One natural sub-module: the data capture register, reusing the existing 32-bit register block (clk, clear, load enable, D, Q). Load enable = REQ & mem_ready.
- FSM and counter stay in the top module.

Test Plan:
- Basic read:
  - Stimulus: clear for 2 cycles, then rd_req=1 with addr_in=32'h0000_0040; mem_ready=1 with mem_data_in=32'hDEAD_BEEF one cycle later.
  - Response: mem_rd high 1 cycle; mem_addr=0x40; data_valid pulses once; bus_out=0xDEADBEEF with bus_out_en=1, and 0 with bus_out_en=0.
- Wait states:
  - Stimulus: mem_ready delayed 5 cycles, data 32'h1234_5678.
  - Response: mem_rd and busy high throughout; single data_valid; no rd_err.
- Ignored requests:
  - Stimulus: rd_req=1 with addr_in=0x80 while in REQ, and again in DONE.
  - Response: mem_addr stays at the first address; exactly one read completes.
- Clear mid-read:
  - Stimulus: assert clear 2 cycles into REQ while a prior value 0xFFFF_FFFF is held.
  - Response: next edge gives mem_rd=0, busy=0, data register=0; no data_valid, even if mem_ready rises later.
- Timeout (MDR_READ_TIMEOUT_EN defined, TIMEOUT_CYCLES=4):
  - Stimulus: mem_ready never asserted.
  - Response: rd_err pulses after the 4th REQ cycle, FSM returns to IDLE, data register keeps its previous value.
- Timeout boundary:
  - Stimulus: mem_ready asserted exactly on the timeout edge.
  - Response: capture occurs, data_valid=1, rd_err=0.

Source files
------------

// File: rtl/mdr_pkg.sv
// rtl/mdr_pkg.sv - shared state encoding and default sizes for the MDR read path
package mdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mdr_state_e;

  localparam int MDR_DATA_WIDTH     = 32;
  localparam int MDR_ADDR_WIDTH     = 32;
  localparam int MDR_TIMEOUT_CYCLES = 16;
  localparam int MDR_CNT_WIDTH      = 5;

endpackage

// File: rtl/mdr_read_unit_reg.sv
// rtl/mdr_read_unit_reg.sv - load-enabled data register with synchronous clear
import mdr_pkg::*;

module mdr_read_unit_reg #(
  parameter int WIDTH = MDR_DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mdr_read_unit.sv
// rtl/mdr_read_unit.sv - memory read FSM feeding the data register onto the bus
// Optional REQ-state timeout abort is built when MDR_READ_TIMEOUT_EN is defined.
import mdr_pkg::*;

module mdr_read_unit #(
  parameter int DATA_WIDTH     = MDR_DATA_WIDTH,
  parameter int ADDR_WIDTH     = MDR_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = MDR_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = MDR_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] addr_in_i,
  input  logic                  bus_out_en_i,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_data_in_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  output logic [DATA_WIDTH-1:0] bus_out_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic                  rd_err_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_cnt_check
    $error("CNT_WIDTH too narrow for TIMEOUT_CYCLES");
  end

  mdr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  data_valid_q, data_valid_d;
  logic                  capture_en;
  logic [DATA_WIDTH-1:0] data_q;

`ifdef MDR_READ_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rd_err_q, rd_err_d;
`endif

  assign capture_en = (state_q == ST_REQ) && mem_ready_i;

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_d     = mem_rd_q;
    data_valid_d = 1'b0;
`ifdef MDR_READ_TIMEOUT_EN
    cnt_d        = cnt_q;
    rd_err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rd_req_i) begin
          mem_addr_d = addr_in_i;
          mem_rd_d   = 1'b1;
          state_d    = ST_REQ;
`ifdef MDR_READ_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_REQ: begin
        // A capture on the timeout edge takes priority over the abort.
        if (mem_ready_i) begin
          mem_rd_d     = 1'b0;
          data_valid_d = 1'b1;
          state_d      = ST_DONE;
        end
`ifdef MDR_READ_TIMEOUT_EN
        else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          mem_rd_d = 1'b0;
          rd_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        mem_rd_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      data_valid_q <= 1'b0;
`ifdef MDR_READ_TIMEOUT_EN
      cnt_q        <= '0;
      rd_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      data_valid_q <= data_valid_d;
`ifdef MDR_READ_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rd_err_q     <= rd_err_d;
`endif
    end
  end

  mdr_read_unit_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_data_reg (
    .clk_i   (clk_i),
    .clear_i (clear_i),
    .load_i  (capture_en),
    .d_i     (mem_data_in_i),
    .q_o     (data_q)
  );

  assign mem_addr_o   = mem_addr_q;
  assign mem_rd_o     = mem_rd_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign bus_out_o    = bus_out_en_i ? data_q : '0;
`ifdef MDR_READ_TIMEOUT_EN
  assign rd_err_o     = rd_err_q;
`else
  assign rd_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_read_unit.sv
// tb/tb_mdr_read_unit.sv - directed self-checking bench for mdr_read_unit
module tb_mdr_read_unit;

  logic        clk = 1'b0;
  logic        clear;
  logic        rd_req;
  logic [31:0] addr_in;
  logic        bus_out_en;
  logic        mem_ready;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] bus_out;
  logic        data_valid;
  logic        busy;
  logic        rd_err;

  int checks = 0;
  int errors = 0;

`ifdef MDR_READ_TIMEOUT_EN
  localparam int WAIT_N = 3;
`else
  localparam int WAIT_N = 5;
`endif

  always #5 clk = ~clk;

  mdr_read_unit #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (4),
    .CNT_WIDTH      (5)
  ) dut (
    .clk_i         (clk),
    .clear_i       (clear),
    .rd_req_i      (rd_req),
    .addr_in_i     (addr_in),
    .bus_out_en_i  (bus_out_en),
    .mem_ready_i   (mem_ready),
    .mem_data_in_i (mem_data_in),
    .mem_addr_o    (mem_addr),
    .mem_rd_o      (mem_rd),
    .bus_out_o     (bus_out),
    .data_valid_o  (data_valid),
    .busy_o        (busy),
    .rd_err_o      (rd_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic e_rd, input logic e_busy,
                         input logic e_dv, input logic e_err);
    chk({tag, "_mem_rd"}, {31'd0, mem_rd}, {31'd0, e_rd});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, "_dv"}, {31'd0, data_valid}, {31'd0, e_dv});
    chk({tag, "_rd_err"}, {31'd0, rd_err}, {31'd0, e_err});
  endtask

  initial begin
    clear = 1'b1; rd_req = 1'b0; addr_in = '0; bus_out_en = 1'b1;
    mem_ready = 1'b1; mem_data_in = 32'h5555_AAAA;
    tick(); tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_bus", bus_out, 32'h0);

    // Basic read, minimum latency; mem_ready in IDLE is ignored
    clear = 1'b0;
    tick();
    chk_ctl("idle_ready", 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0; rd_req = 1'b1; addr_in = 32'h0000_0040;
    tick();
    chk_ctl("basic_req", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("basic_addr", mem_addr, 32'h0000_0040);
    rd_req = 1'b0; mem_ready = 1'b1; mem_data_in = 32'hDEAD_BEEF;
    tick();
    chk_ctl("basic_done", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("basic_bus_en", bus_out, 32'hDEAD_BEEF);
    mem_ready = 1'b0; mem_data_in = 32'h0;
    tick();
    chk_ctl("basic_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    bus_out_en = 1'b0;
    #1;
    chk("basic_bus_dis", bus_out, 32'h0);
    bus_out_en = 1'b1;
    #1;
    chk("basic_bus_hold", bus_out, 32'hDEAD_BEEF);

    // Wait states
    rd_req = 1'b1; addr_in = 32'h0000_0100; mem_data_in = 32'h1234_5678;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < WAIT_N; i++) begin
      tick();
      chk_ctl("wait_req", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("wait_bus_old", bus_out, 32'hDEAD_BEEF);
    mem_ready = 1'b1;
    tick();
    chk_ctl("wait_done", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wait_bus", bus_out, 32'h1234_5678);
    mem_ready = 1'b0;
    tick();
    chk_ctl("wait_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Requests during REQ and DONE are ignored
    rd_req = 1'b1; addr_in = 32'h0000_0200;
    tick();
    addr_in = 32'h0000_0080;
    tick();
    chk("ign_req_addr", mem_addr, 32'h0000_0200);
    chk_ctl("ign_req", 1'b1, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1; mem_data_in = 32'hA5A5_0001;
    tick();
    chk_ctl("ign_done", 1'b0, 1'b1, 1'b1, 1'b0);
    mem_ready = 1'b0;
    tick();
    chk_ctl("ign_after_done", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ign_done_addr", mem_addr, 32'h0000_0200);
    rd_req = 1'b0;
    tick();
    chk_ctl("ign_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ign_bus", bus_out, 32'hA5A5_0001);

    // Clear mid-read, with 0xFFFFFFFF held beforehand
    rd_req = 1'b1; addr_in = 32'h0000_0300;
    tick();
    rd_req = 1'b0; mem_ready = 1'b1; mem_data_in = 32'hFFFF_FFFF;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("clr_prior", bus_out, 32'hFFFF_FFFF);
    rd_req = 1'b1; addr_in = 32'h0000_0400;
    tick();
    rd_req = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    chk_ctl("clr_edge", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_bus", bus_out, 32'h0);
    chk("clr_addr", mem_addr, 32'h0);
    clear = 1'b0; mem_ready = 1'b1; mem_data_in = 32'h1111_1111;
    tick();
    chk_ctl("clr_late_ready", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_late_bus", bus_out, 32'h0);
    mem_ready = 1'b0;

`ifdef MDR_READ_TIMEOUT_EN
    // Timeout abort keeps the previously captured word
    rd_req = 1'b1; addr_in = 32'h0000_0500; mem_data_in = 32'hCAFE_F00D;
    tick();
    rd_req = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_data_in = 32'h0;
    tick();
    rd_req = 1'b1; addr_in = 32'h0000_0600;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctl("to_req", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_ctl("to_abort", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("to_bus", bus_out, 32'hCAFE_F00D);
    tick();
    chk_ctl("to_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Ready on the timeout edge wins
    rd_req = 1'b1; addr_in = 32'h0000_0700;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    mem_ready = 1'b1; mem_data_in = 32'h0BAD_CAFE;
    tick();
    chk_ctl("tb_edge", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tb_bus", bus_out, 32'h0BAD_CAFE);
    mem_ready = 1'b0;
    tick();
    chk_ctl("tb_idle", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
